// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with request/ready handshake, programmable wait states and byte lanes.
// Optional: define MISALIGN_TRAP_EN to reject accesses whose addr is not a multiple of BYTES.
module data_mem_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_read,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0] data_reg,
  output logic              dm_ready,
  output logic              dm_err,
  output logic              dm_busy
);
  localparam int BYTES = DATA_W / 8;
  localparam logic [7:0] WAIT_INIT = (WAIT_CYC > 0) ? 8'(WAIT_CYC - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  be;
  } req_t;

  logic [7:0] mem [0:(2**ADDR_W)-1];

  state_t            state_q;
  logic [7:0]        cnt_q;
  req_t              req_q;
  logic [DATA_W-1:0] data_q;
  logic              ready_q, err_q, busy_q;
  logic              trap;

`ifdef MISALIGN_TRAP_EN
  assign trap = (addr % ADDR_W'(BYTES)) != '0;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dm_read && dm_wr) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (dm_read || dm_wr) begin
            busy_q <= 1'b1;
            if (trap) begin
              state_q <= S_DONE;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              req_q.wr   <= dm_wr;
              req_q.addr <= addr;
              req_q.data <= wr_data;
              req_q.be   <= byte_en;
              if (WAIT_CYC > 0) begin
                state_q <= S_WAIT;
                cnt_q   <= WAIT_INIT;
              end else begin
                state_q <= S_ACCESS;
              end
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        S_ACCESS: begin
          // unselected read lanes return zero rather than holding stale bytes
          if (!req_q.wr)
            for (int k = 0; k < BYTES; k++)
              data_q[8*k +: 8] <= req_q.be[k] ? mem[req_q.addr + ADDR_W'(k)] : 8'h00;
          state_q <= S_DONE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array is not reset; a reset simply prevents the ACCESS state from being reached.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && req_q.wr)
      for (int k = 0; k < BYTES; k++)
        if (req_q.be[k]) mem[req_q.addr + ADDR_W'(k)] <= req_q.data[8*k +: 8];
  end

  assign data_reg = data_q;
  assign dm_ready = ready_q;
  assign dm_err   = err_q;
  assign dm_busy  = busy_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (WAIT_CYC 0, 1, 3) share stimulus and a byte-array reference model.
module tb_data_mem_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        dm_read = 0, dm_wr = 0;
  logic [15:0] addr = 0, wr_data = 0;
  logic [1:0]  byte_en = 0;
  logic [2:0][15:0] dreg;
  logic [2:0]  rdy, err, busy;

  int n_assert = 0, n_fail = 0;
  logic [7:0]  mem_m [0:65535];
  logic [15:0] data_m = 16'h0;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .dm_read(dm_read), .dm_wr(dm_wr), .addr(addr), .wr_data(wr_data),
    .byte_en(byte_en), .data_reg(dreg[0]), .dm_ready(rdy[0]), .dm_err(err[0]), .dm_busy(busy[0]));
  data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .dm_read(dm_read), .dm_wr(dm_wr), .addr(addr), .wr_data(wr_data),
    .byte_en(byte_en), .data_reg(dreg[1]), .dm_ready(rdy[1]), .dm_err(err[1]), .dm_busy(busy[1]));
  data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .dm_read(dm_read), .dm_wr(dm_wr), .addr(addr), .wr_data(wr_data),
    .byte_en(byte_en), .data_reg(dreg[2]), .dm_ready(rdy[2]), .dm_err(err[2]), .dm_busy(busy[2]));

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: an access is a byte-array update/lookup; errors leave everything untouched.
  task automatic model(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be, output bit e);
    logic [15:0] la;
    e = (rd && wr) || (TRAP && (a % 2 != 0));
    if (!e) begin
      for (int k = 0; k < 2; k++) begin
        la = a + 16'(k);
        if (wr && be[k]) mem_m[la] = d[8*k +: 8];
        if (rd) data_m[8*k +: 8] = be[k] ? mem_m[la] : 8'h00;
      end
    end
  endtask

  // Presents one request at the next edge and observes each instance for 8 cycles.
  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be, input bit hold2);
    bit e;
    int lat;
    int first [3], pulses [3], stray [3];
    bit busy_ok [3], err_at [3];
    for (int i = 0; i < 3; i++) begin
      first[i] = -1; pulses[i] = 0; stray[i] = 0; busy_ok[i] = 1; err_at[i] = 0;
    end
    dm_read = rd; dm_wr = wr; addr = a; wr_data = d; byte_en = be;
    model(rd, wr, a, d, be, e);
    @(posedge clk);
    #1;
    if (!hold2) begin
      dm_read = 0; dm_wr = 0;
      addr = 16'($urandom); wr_data = 16'($urandom); byte_en = 2'($urandom);
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        lat = e ? 0 : 1 + wc(i);
        if (rdy[i] === 1'b1) begin
          pulses[i]++;
          if (first[i] < 0) begin first[i] = n; err_at[i] = err[i]; end
        end else if (err[i] !== 1'b0) stray[i]++;
        if (busy[i] !== (n <= lat)) busy_ok[i] = 0;
      end
      if (n == 1) begin dm_read = 0; dm_wr = 0; end
    end
    for (int i = 0; i < 3; i++) begin
      lat = e ? 0 : 1 + wc(i);
      chk($sformatf("%s/w%0d ready_pulses", tag, wc(i)), pulses[i], 1);
      chk($sformatf("%s/w%0d ready_cycle", tag, wc(i)), first[i], lat);
      chk($sformatf("%s/w%0d err", tag, wc(i)), {31'd0, err_at[i]} | stray[i], {31'd0, e});
      chk($sformatf("%s/w%0d busy_window", tag, wc(i)), {31'd0, busy_ok[i]}, 32'd1);
      chk($sformatf("%s/w%0d data_reg", tag, wc(i)), dreg[i], data_m);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, d;
    int r;
    #3;
    chk("reset_flags", {29'd0, rdy, err, busy} , 32'd0);
    chk("reset_data", {dreg[0] | dreg[1] | dreg[2]}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // abort a write mid-WAIT: memory must keep the older contents
    do_op("wr10", 0, 1, 16'h0010, 16'h1111, 2'b11, 0);
    do_op("rd10", 1, 0, 16'h0010, 16'h0000, 2'b11, 0);
    dm_wr = 1; addr = 16'h0010; wr_data = 16'h2222; byte_en = 2'b11;
    @(posedge clk);
    #1; dm_wr = 0;
    #2; rst_n = 0;
    #1;
    chk("midreset_flags", {29'd0, rdy, err, busy}, 32'd0);
    chk("midreset_data", {dreg[0] | dreg[1] | dreg[2]}, 32'd0);
    data_m = 16'h0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    do_op("rd10_after_rst", 1, 0, 16'h0010, 16'h0000, 2'b11, 0);

    do_op("wr20", 0, 1, 16'h0020, 16'hBEEF, 2'b11, 0);
    do_op("rd20", 1, 0, 16'h0020, 16'h0000, 2'b11, 0);

    do_op("wr40", 0, 1, 16'h0040, 16'h1234, 2'b11, 0);
    do_op("wr40_hi", 0, 1, 16'h0040, 16'hAB00, 2'b10, 0);
    do_op("rd40", 1, 0, 16'h0040, 16'h0000, 2'b11, 0);
    do_op("rd40_lo", 1, 0, 16'h0040, 16'h0000, 2'b01, 0);
    do_op("rd40_none", 1, 0, 16'h0040, 16'h0000, 2'b00, 0);
    do_op("wr40_none", 0, 1, 16'h0040, 16'hFFFF, 2'b00, 0);
    do_op("rd40_again", 1, 0, 16'h0040, 16'h0000, 2'b11, 0);

    do_op("wr0000", 0, 1, 16'h0000, 16'h3C3C, 2'b11, 0);
    do_op("wr_wrap", 0, 1, 16'hFFFF, 16'hA55A, 2'b11, 0);
    do_op("rd_ffff", 1, 0, 16'hFFFF, 16'h0000, 2'b01, 0);
    do_op("rd_0000", 1, 0, 16'h0000, 16'h0000, 2'b01, 0);

    do_op("illegal_held", 1, 1, 16'h0040, 16'h9999, 2'b11, 1);
    do_op("rd40_post_ill", 1, 0, 16'h0040, 16'h0000, 2'b11, 0);

    do_op("wr22", 0, 1, 16'h0022, 16'h7766, 2'b11, 0);
    do_op("rd20b", 1, 0, 16'h0020, 16'h0000, 2'b11, 0);
    do_op("rd21_mis", 1, 0, 16'h0021, 16'h0000, 2'b11, 0);

    for (int k = 0; k < 9; k++)
      do_op("prefill", 0, 1, 16'h0100 + 16'(2 * k), 16'($urandom), 2'b11, 0);
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      a = 16'h0100 + 16'($urandom_range(0, 15));
      d = 16'($urandom);
      if (r == 0)     do_op("rnd_ill", 1, 1, a, d, 2'($urandom), 1'($urandom));
      else if (r < 5) do_op("rnd_wr", 0, 1, a, d, 2'($urandom), 0);
      else            do_op("rnd_rd", 1, 0, a, d, 2'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
